// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the CPU data-memory request interface. Accepts one
//   load/store at a time on a valid/ready handshake and answers it after
//   LATENCY wait cycles. All state updates on the falling edge of clk so
//   the block lines up with the pipeline stage registers.
//
// Ports
//   clk        clock (state updates on negedge)
//   reset      asynchronous active-low reset
//   req_*      request channel: valid/ready, byte address, store data,
//              write flag, access mode (0 SB/LB, 1 SH/LH, 2 W, 4 LBU, 5 LHU)
//   resp_*     response channel: valid/ready, load data, error flag
module data_mem_responder #(
    parameter int unsigned DEPTH   = 256,  // must be >= 2
    parameter int unsigned LATENCY = 2     // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    input  logic [2:0]  req_mode,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [2:0]  mode_q, mode_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic        in_range;
    logic [31:0] rd_word;
    logic [4:0]  bit_off;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        acc_err;
    logic [31:0] load_val;
    logic [31:0] wmask;
    logic [31:0] wdat;
    logic [31:0] merged;
    logic        mem_we;

    // Access decode works on the latched request so it is stable in WAIT.
    assign in_range = ({2'b00, addr_q[31:2]} < DEPTH);
    assign rd_word  = mem_q[addr_q[IdxW+1:2]];
    assign bit_off  = {addr_q[1:0], 3'b000};
    assign byte_val = 8'(rd_word >> bit_off);
    assign half_val = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        acc_err  = 1'b0;
        load_val = '0;
        wmask    = '0;
        wdat     = '0;
        case (mode_q)
            3'd0, 3'd4: begin
                load_val = mode_q[2] ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
                wmask    = 32'h0000_00ff << bit_off;
                wdat     = {4{wdata_q[7:0]}};
            end
            3'd1, 3'd5: begin
                acc_err  = addr_q[0];
                load_val = mode_q[2] ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
                wmask    = addr_q[1] ? 32'hffff_0000 : 32'h0000_ffff;
                wdat     = {2{wdata_q[15:0]}};
            end
            3'd2: begin
                acc_err  = (addr_q[1:0] != 2'b00);
                load_val = rd_word;
                wmask    = '1;
                wdat     = wdata_q;
            end
            default: acc_err = 1'b1;
        endcase
        // Unsigned modes are load-only.
        if (mode_q[2] && write_q) acc_err = 1'b1;
        if (!in_range)            acc_err = 1'b1;
    end

    // Read-modify-write keeps untouched lanes of the word.
    assign merged = (rd_word & ~wmask) | (wdat & wmask);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        mode_d  = mode_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    mode_d  = req_mode;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    mem_we  = write_q && !acc_err;
                    rdata_d = (write_q || acc_err) ? 32'd0 : load_val;
                    err_d   = acc_err;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            mode_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            mode_q  <= mode_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Backing store is deliberately not reset. mem_we is derived from the
    // async-reset FSM, so a reset before the commit edge drops the write.
    always_ff @(negedge clk) begin
        if (mem_we) mem_q[addr_q[IdxW+1:2]] <= merged;
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_write = 1'b0;
    logic [2:0]  req_mode = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_chk = 0;
    int n_bad = 0;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_write  (req_write),
        .req_mode   (req_mode),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Issue one request from IDLE, wait for the response, consume it.
    // lat counts falling edges from the accept edge up to resp_valid.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic w,
                          input logic [2:0] m, output logic [31:0] rd, output logic er,
                          output int lat);
        req_addr  = a;
        req_wdata = wd;
        req_write = w;
        req_mode  = m;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            step();
            lat++;
        end
        check_eq("resp_arrives", {31'b0, resp_valid}, 32'd1);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        // Reset state
        step();
        step();
        check_eq("rst_req_ready",  {31'b0, req_ready},  32'd1);
        check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("rst_resp_rdata", resp_rdata,          32'd0);
        check_eq("rst_resp_err",   {31'b0, resp_err},   32'd0);
        reset = 1'b1;
        step();

        // Word round trip + latency (3 edges counting the accept edge)
        do_req(32'h10, 32'hdeadbeef, 1'b1, 3'd2, rd, er, lat);
        check_eq("sw_err", {31'b0, er}, 32'd0);
        check_eq("sw_rdata", rd, 32'd0);
        check_eq("sw_lat", 32'(lat), 32'd3);
        do_req(32'h10, 32'h0, 1'b0, 3'd2, rd, er, lat);
        check_eq("lw_rdata", rd, 32'hdeadbeef);
        check_eq("lw_err", {31'b0, er}, 32'd0);
        check_eq("lw_lat", 32'(lat), 32'd3);

        // Byte/half extension
        do_req(32'h20, 32'h80ff7f01, 1'b1, 3'd2, rd, er, lat);
        do_req(32'h23, 32'h0, 1'b0, 3'd0, rd, er, lat);
        check_eq("lb_23", rd, 32'hffffff80);
        do_req(32'h23, 32'h0, 1'b0, 3'd4, rd, er, lat);
        check_eq("lbu_23", rd, 32'h00000080);
        do_req(32'h22, 32'h0, 1'b0, 3'd1, rd, er, lat);
        check_eq("lh_22", rd, 32'hffff80ff);
        do_req(32'h20, 32'h0, 1'b0, 3'd5, rd, er, lat);
        check_eq("lhu_20", rd, 32'h00007f01);
        do_req(32'h21, 32'h0, 1'b0, 3'd0, rd, er, lat);
        check_eq("lb_21", rd, 32'h0000007f);

        // Partial stores
        do_req(32'h30, 32'h11223344, 1'b1, 3'd2, rd, er, lat);
        do_req(32'h31, 32'h000000aa, 1'b1, 3'd0, rd, er, lat);
        check_eq("sb_err", {31'b0, er}, 32'd0);
        do_req(32'h32, 32'h0000beef, 1'b1, 3'd1, rd, er, lat);
        do_req(32'h30, 32'h0, 1'b0, 3'd2, rd, er, lat);
        check_eq("partial_lw", rd, 32'hbeefaa44);

        // Errors
        do_req(32'h13, 32'h0, 1'b0, 3'd2, rd, er, lat);
        check_eq("lw_misal_err", {31'b0, er}, 32'd1);
        check_eq("lw_misal_rdata", rd, 32'd0);
        check_eq("err_lat", 32'(lat), 32'd3);
        do_req(32'h40, 32'hcafef00d, 1'b1, 3'd2, rd, er, lat);
        do_req(32'h0, 32'h01020304, 1'b1, 3'd2, rd, er, lat);
        do_req(32'h41, 32'h00001111, 1'b1, 3'd1, rd, er, lat);
        check_eq("sh_misal_err", {31'b0, er}, 32'd1);
        do_req(32'h40, 32'h00000055, 1'b1, 3'd4, rd, er, lat);
        check_eq("sbu_err", {31'b0, er}, 32'd1);
        do_req(32'h40, 32'h0, 1'b0, 3'd2, rd, er, lat);
        check_eq("after_bad_st", rd, 32'hcafef00d);
        do_req(32'h400, 32'h99999999, 1'b1, 3'd2, rd, er, lat);
        check_eq("sw_oob_err", {31'b0, er}, 32'd1);
        do_req(32'h400, 32'h0, 1'b0, 3'd2, rd, er, lat);
        check_eq("lw_oob_err", {31'b0, er}, 32'd1);
        check_eq("lw_oob_rdata", rd, 32'd0);
        do_req(32'h0, 32'h0, 1'b0, 3'd2, rd, er, lat);
        check_eq("no_alias_write", rd, 32'h01020304);
        do_req(32'h10, 32'h0, 1'b0, 3'd6, rd, er, lat);
        check_eq("mode6_err", {31'b0, er}, 32'd1);
        check_eq("mode6_rdata", rd, 32'd0);
        do_req(32'h10, 32'h0, 1'b0, 3'd3, rd, er, lat);
        check_eq("mode3_err", {31'b0, er}, 32'd1);

        // Backpressure
        req_addr  = 32'h10;
        req_write = 1'b0;
        req_mode  = 3'd2;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            step();
            lat++;
        end
        check_eq("bp_arrive", {31'b0, resp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_addr  = 32'h20;
                req_valid = 1'b1;
            end
            step();
            req_valid = 1'b0;
            check_eq("bp_valid", {31'b0, resp_valid}, 32'd1);
            check_eq("bp_rdata", resp_rdata, 32'hdeadbeef);
            check_eq("bp_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check_eq("bp_rel_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("bp_rel_ready", {31'b0, req_ready}, 32'd1);
        check_eq("bp_rdata_held", resp_rdata, 32'hdeadbeef);
        step();
        check_eq("bp_pulse_dropped", {31'b0, req_ready}, 32'd1);
        req_addr  = 32'h20;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check_eq("bp_next_accept", {31'b0, req_ready}, 32'd0);
        lat = 1;
        while (!resp_valid && lat < 50) begin
            step();
            lat++;
        end
        check_eq("bp_next_rdata", resp_rdata, 32'h80ff7f01);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Reset mid-WAIT drops an uncommitted store
        do_req(32'h50, 32'h0, 1'b1, 3'd2, rd, er, lat);
        req_addr  = 32'h50;
        req_wdata = 32'h12345678;
        req_write = 1'b1;
        req_mode  = 3'd2;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check_eq("rw_in_wait", {31'b0, req_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rw_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("rw_req_ready", {31'b0, req_ready}, 32'd1);
        step();
        step();
        reset = 1'b1;
        step();
        do_req(32'h50, 32'h0, 1'b0, 3'd2, rd, er, lat);
        check_eq("rw_no_commit", rd, 32'd0);
        do_req(32'h30, 32'h0, 1'b0, 3'd2, rd, er, lat);
        check_eq("rw_mem_kept", rd, 32'hbeefaa44);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (memory) end of the CPU data-memory request interface.
- Accepts one load/store request at a time over a valid/ready handshake and services it after a programmable latency.
- Returns read data, or a store acknowledge, over a response handshake.
- Stands in for the combinational DataMemory when the pipeline is moved to a stalling, multi-cycle memory.

Parameters:
DEPTH, 256, number of 32-bit words in the backing array; word index is addr[31:2].
LATENCY, 2, cycles spent in WAIT between request accept and response valid; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on the negedge of clk, matching the pipeline stage registers
reset  input  1  asynchronous, active-low reset (reset==0 resets)
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  32  byte address
req_wdata  input  32  store data; byte/half stores use the low bits
req_write  input  1  1=store, 0=load
req_mode  input  3  0=byte signed, 1=half signed, 2=word, 4=byte unsigned, 5=half unsigned
resp_valid  output  1  response present
resp_ready  input  1  requester consumes the response
resp_rdata  output  32  load result, extended per mode; 0 for stores and errors
resp_err  output  1  request was rejected (see error rules)

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
- The memory array is not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready at a negedge:
  - latch addr, wdata, write, mode;
  - load counter with LATENCY-1;
  - go to WAIT.
- WAIT: req_ready=0. The counter decrements each edge. On the edge where the counter is 0:
  - perform the access and register resp_rdata/resp_err;
  - go to RESP.
  - Accept-to-resp_valid latency is exactly LATENCY+1 edges (the accept edge plus LATENCY WAIT edges).
- RESP: resp_valid=1, with rdata/err held stable.
  - On resp_ready at a negedge: go to IDLE and clear resp_valid.
  - resp_rdata and resp_err keep their last values.
  - req_ready is 0 in RESP, so back-to-back requests are separated by at least one IDLE cycle.
- Memory is little-endian: the byte at addr is bits [8*addr[1:0]+7 : 8*addr[1:0]] of the word.
- Loads:
  - byte: sign-extend (mode 0) or zero-extend (mode 4);
  - half: bits from addr[1]*16, sign-extend (mode 1) or zero-extend (mode 5);
  - word: as stored.
- Stores are read-modify-write of the addressed word:
  - mode 0 writes only the addressed byte from wdata[7:0];
  - mode 1 writes only the addressed half from wdata[15:0];
  - mode 2 writes the full word.
  - Other bytes are unchanged. The write commits on the WAIT->RESP edge only.
- Error conditions set resp_err=1 and resp_rdata=0, suppress any write, and still take the full latency:
  - half access with addr[0]!=0;
  - word access with addr[1:0]!=0;
  - addr[31:2] >= DEPTH;
  - mode 3, 6 or 7;
  - mode 4 or 5 with req_write=1.
- Request inputs are ignored outside IDLE, and req_valid in WAIT/RESP has no effect.
- Reset asserted mid-operation:
  - the FSM returns to IDLE immediately and the pending request is dropped;
  - a write that has not reached its commit edge does not occur;
  - a write already committed stays committed.
- resp_valid deasserts only via resp_ready or reset. A stalled requester may hold resp_ready=0 indefinitely.

Test Plan:
- Word round trip: store addr=0x10, wdata=0xDEADBEEF, mode=2, then load addr=0x10 mode=2 -> resp_rdata=0xDEADBEEF, resp_err=0; resp_valid rises exactly 3 edges after accept (LATENCY=2).
- Byte/half extension: after word 0x80FF7F01 at 0x20:
  - LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080;
  - LH 0x22 -> 0xFFFF80FF; LHU 0x20 -> 0x00007F01.
- Partial store: word 0x11223344 at 0x30, SB wdata=0xAA at 0x31, SH wdata=0xBEEF at 0x32, then LW 0x30 -> 0xBEEFAA44.
- Errors:
  - LW 0x13 -> resp_err=1, rdata=0;
  - SH 0x41 and SW to byte address 4*DEPTH -> resp_err=1, and a later LW shows the target unchanged;
  - mode 6 -> resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0, and a new req_valid pulse is not accepted; release -> IDLE, next request accepted one edge later.
- Reset mid-WAIT: SW 0x50 = 0x12345678 over prior 0, assert reset during WAIT -> resp_valid=0, req_ready=1; LW 0x50 -> 0x00000000.
